// File: rtl/execution_controller_pkg.sv
// Shared ISA definitions: opcodes, ALU operation encodings, controller states and field layout.
// No latency or backpressure of its own; the decoder, ALU and controller all import it.
package execution_controller_pkg;

  localparam logic [5:0] OP_LI    = 6'b110000;
  localparam logic [5:0] OP_ADD   = 6'b010000;
  localparam logic [5:0] OP_MUL   = 6'b100000;
  localparam logic [5:0] OP_STORE = 6'b111000;

  typedef enum logic [1:0] {
    ALU_PASS_IMM = 2'b00,
    ALU_ADD      = 2'b01,
    ALU_MUL      = 2'b10,
    ALU_ADD_IMM  = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WAIT, ST_WB, ST_HALT
  } state_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } fields_t;

  function automatic logic op_legal(input logic [5:0] opcode);
    return (opcode == OP_LI) || (opcode == OP_ADD) ||
           (opcode == OP_MUL) || (opcode == OP_STORE);
  endfunction

  function automatic alu_op_e op_to_alu(input logic [5:0] opcode);
    alu_op_e op;
    case (opcode)
      OP_ADD:   op = ALU_ADD;
      OP_MUL:   op = ALU_MUL;
      OP_STORE: op = ALU_ADD_IMM;
      default:  op = ALU_PASS_IMM;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/execution_controller_if.sv
// Controller-side bundle: run control, decoder word, ALU/memory handshakes and datapath controls.
// master = environment (decoder/ALU/memory), slave = execution_controller.
interface execution_controller_if;
  logic        start;
  logic [31:0] instruction;
  logic        alu_done;
  logic        mem_ready;
  logic        fetch_en;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [15:0] imm;
  logic [1:0]  alu_op;
  logic        alu_start;
  logic        reg_write;
  logic        mem_write;
  logic        busy;
  logic        halted;
  logic        illegal;

  modport master (
    output start, instruction, alu_done, mem_ready,
    input  fetch_en, rs_addr, rt_addr, rd_addr, imm, alu_op,
           alu_start, reg_write, mem_write, busy, halted, illegal
  );

  modport slave (
    input  start, instruction, alu_done, mem_ready,
    output fetch_en, rs_addr, rt_addr, rd_addr, imm, alu_op,
           alu_start, reg_write, mem_write, busy, halted, illegal
  );
endinterface

// File: rtl/execution_controller_field_extractor.sv
// Purely combinational split of a 32-bit instruction word into opcode/rs/rt/rd/imm.
// Zero latency, no backpressure.
module field_extractor
  import execution_controller_pkg::*;
(
  input  logic [31:0] instr,
  output fields_t     fields
);
  assign fields.opcode = instr[31:26];
  assign fields.rs     = instr[25:21];
  assign fields.rt     = instr[20:16];
  assign fields.rd     = instr[15:11];
  assign fields.imm    = instr[15:0];
endmodule

// File: rtl/execution_controller.sv
// Sequences PROG_LEN instructions through FETCH/DECODE/EXEC/(WAIT)/WB, then halts until reset.
// LI/ADD take 4 cycles; MUL stalls in WAIT for alu_done; STORE holds mem_write until mem_ready.
module execution_controller
  import execution_controller_pkg::*;
#(
  parameter int PROG_LEN = 6,
  parameter int ITW      = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  execution_controller_if.slave  bus
);
  // One spare bit lets the counter hold PROG_LEN even when PROG_LEN == 2**ITW.
  localparam int CW = ITW + 1;

  state_e          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  fields_t         fields;
  logic            last;
  logic            is_rd_type;

  field_extractor u_field_extractor (
    .instr  (instr_q),
    .fields (fields)
  );

  assign last       = (cnt_q == CW'(PROG_LEN));
  assign is_rd_type = (fields.opcode == OP_ADD) || (fields.opcode == OP_MUL);

  // Fields come straight from the latched word, so they hold from DECODE until the next FETCH.
  assign bus.rs_addr = fields.rs;
  assign bus.rt_addr = fields.rt;
  assign bus.rd_addr = is_rd_type ? fields.rd : fields.rt;
  assign bus.imm     = fields.imm;
  assign bus.alu_op  = op_to_alu(fields.opcode);
  assign bus.busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign bus.halted  = (state_q == ST_HALT);
  assign bus.illegal = illegal_q;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    cnt_d         = cnt_q;
    illegal_d     = illegal_q;
    bus.fetch_en  = 1'b0;
    bus.alu_start = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        bus.fetch_en = 1'b1;
        instr_d      = bus.instruction;
        if (!last) cnt_d = cnt_q + CW'(1);
        state_d      = ST_DECODE;
      end
      ST_DECODE: begin
        if (op_legal(fields.opcode)) begin
          state_d = ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_EXEC: begin
        if (fields.opcode == OP_MUL) begin
          bus.alu_start = 1'b1;
          state_d       = ST_WAIT;
        end else if (fields.opcode == OP_STORE) begin
          bus.mem_write = 1'b1;
          if (bus.mem_ready) state_d = last ? ST_HALT : ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WAIT: begin
        if (bus.alu_done) state_d = ST_WB;
      end
      ST_WB: begin
        bus.reg_write = 1'b1;
        state_d       = last ? ST_HALT : ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: doc/execution_controller.md
EXECUTION_CONTROLLER -- requirements
Module: execution_controller

Interface
REQ-001 Parameter PROG_LEN, default 6: number of instructions executed per run before halting.
REQ-002 Parameter ITW, default 3: width of the instruction counter; SHALL satisfy 2^ITW >= PROG_LEN.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 start  input  1  one-cycle pulse; begins a run from IDLE; ignored in every other state.
REQ-006 instruction  input  32  word from instruction decoder; valid only in the cycle fetch_en=1.
REQ-007 alu_done  input  1  multi-cycle ALU completion; a one-cycle pulse.
REQ-008 mem_ready  input  1  store acceptance from data memory; a level signal.
REQ-009 fetch_en  output  1  drives the decoder control input; advances the decoder pc by one.
REQ-010 rs_addr, rt_addr, rd_addr  output  5 each  register addresses latched from the current instruction.
REQ-011 imm  output  16  immediate field, instruction[15:0].
REQ-012 alu_op  output  2  00 pass-imm, 01 add, 10 mul, 11 add-imm (address).
REQ-013 alu_start  output  1  one-cycle launch pulse for mul.
REQ-014 reg_write  output  1  one-cycle register-file write strobe to the destination register.
REQ-015 mem_write  output  1  store request; held until accepted.
REQ-016 busy, halted, illegal  output  1 each  run in progress / run finished / illegal opcode seen.

Function
REQ-017 FSM states SHALL be: IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALT.
REQ-018 IDLE->FETCH on start=1; busy SHALL be 1 in every state except IDLE and HALT.
REQ-019 FETCH SHALL assert fetch_en for exactly one cycle, latch instruction into an internal register in the same cycle, increment the instruction counter, and go to DECODE.
REQ-020 DECODE SHALL split the latched word into opcode[31:26], rs[25:21], rt[20:16], rd[15:11] and imm[15:0]; rd_addr=rt for LI/STORE and rd for ADD/MUL; then go to EXEC.
REQ-021 Opcodes: 110000 LI, 010000 ADD, 100000 MUL, 111000 STORE; any other opcode SHALL set illegal=1 and go to HALT without issuing a write.
REQ-022 LI/ADD: EXEC sets alu_op (00/01) -> WB; WB asserts reg_write for one cycle; total 4 cycles FETCH-to-WB.
REQ-023 MUL: EXEC asserts alu_start for one cycle with alu_op=10 -> WAIT; WAIT holds until alu_done=1 -> WB.
REQ-024 STORE: EXEC asserts mem_write with alu_op=11 and holds it each cycle until mem_ready=1; the state then proceeds with no WB and no reg_write.
REQ-025 After WB, or after an accepted STORE: if the counter equals PROG_LEN, go to HALT; otherwise go to FETCH.
REQ-026 HALT SHALL hold halted=1 with busy=0 until reset; start is ignored in HALT.
REQ-027 alu_done arriving outside WAIT SHALL be ignored; alu_done and mem_ready in the same cycle act only on the state-relevant one.
REQ-028 Address, imm and alu_op outputs SHALL stay stable from DECODE through the last cycle of WB/EXEC for that instruction.
REQ-029 The counter SHALL never wrap; it saturates at PROG_LEN.

Reset
REQ-030 reset=0 at a clock edge SHALL force IDLE, counter=0, and all outputs 0, including from mid-WAIT or mid-STORE.
REQ-031 The same reset SHALL be routed to the instruction decoder so that pc and counter realign to 0.

Structure
REQ-032 Opcode constants, alu_op encodings and the state encoding SHALL live in a shared package (isa_pkg) used by the decoder and the ALU.
REQ-033 A single sub-module, field_extractor (combinational split of the 32-bit word into fields), is natural; the FSM stays in execution_controller.

Verification
REQ-034 Six-instruction program (LI r10,10; LI r15,15; ADD r25; STORE; LI r5,2; MUL r30), alu_done 3 cycles after alu_start, mem_ready immediate -> exactly 6 fetch_en pulses, 5 reg_write pulses, 1 mem_write, then halted=1.
REQ-035 MUL with alu_done delayed 10 cycles -> controller stays in WAIT for 10 cycles with no reg_write, then exactly 1 reg_write with rd_addr=30.
REQ-036 STORE with mem_ready low for 4 cycles -> mem_write held high for 5 cycles, no fetch_en during that time.
REQ-037 Opcode 000001 at slot 2 -> illegal=1, halted=1, and no further fetch_en or reg_write.
REQ-038 reset=0 asserted in WAIT, then start -> all outputs are 0 the cycle after reset; the next fetch returns instruction 0 (LI r10).
REQ-039 start pulsed during the run and during HALT -> no effect; fetch_en count is unchanged.
